// File: rtl/hovalaag_sequencer.sv
// Serialises one instruction-step command onto the HovalaagWrapper addr/io_in bus
// and collects status, PC and OUT into a single response word.
module hovalaag_sequencer #(
    parameter int unsigned SKIP_OUT_READ = 1,
    parameter int unsigned COUNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [31:0]            cmd_instr,
    input  logic                   cmd_ld_in1,
    input  logic                   cmd_ld_in2,
    input  logic [11:0]            cmd_in1,
    input  logic [11:0]            cmd_in2,
    output logic [9:0]             hv_addr,
    output logic [5:0]             hv_wdata,
    input  logic [7:0]             hv_rdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [3:0]             rsp_status,
    output logic [7:0]             rsp_pc,
    output logic [11:0]            rsp_out,
    output logic [COUNT_WIDTH-1:0] exec_count
);
    localparam int unsigned AW = 10;
    localparam int unsigned DW = 6;
    localparam int unsigned IW = 32;
    localparam int unsigned VW = 12;

    typedef enum logic [3:0] {
        IDLE, LD1L, LD1H, LD2L, LD2H, I0, I1, I2, I3, I4, EXEC, RDPC, RDOL, RDOH, RESP
    } state_t;

    state_t          state, next_state;
    state_t          bus_st;
    logic [IW-1:0]   instr_q;
    logic [VW-1:0]   in1_q;
    logic [VW-1:0]   in2_q;
    logic            ld_in2_q;
    logic [AW-1:0]   addr_c;
    logic [DW-1:0]   wdata_c;
    logic            accept;

    assign accept = cmd_valid && cmd_ready;

    // Next state plus the bus word the current state drives on the next cycle
    always_comb begin
        next_state = state;
        addr_c     = '0;
        wdata_c    = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (cmd_ld_in1)      next_state = LD1L;
                    else if (cmd_ld_in2) next_state = LD2L;
                    else                 next_state = I0;
                end
            end
            LD1L: begin next_state = LD1H; addr_c = AW'(1) << 6; wdata_c = in1_q[5:0];  end
            LD1H: begin
                next_state = ld_in2_q ? LD2L : I0;
                addr_c     = AW'(1) << 7;
                wdata_c    = in1_q[11:6];
            end
            LD2L: begin next_state = LD2H; addr_c = AW'(1) << 8; wdata_c = in2_q[5:0];  end
            LD2H: begin next_state = I0;   addr_c = AW'(1) << 9; wdata_c = in2_q[11:6]; end
            I0:   begin next_state = I1;   addr_c = AW'(1) << 0; wdata_c = instr_q[5:0];   end
            I1:   begin next_state = I2;   addr_c = AW'(1) << 1; wdata_c = instr_q[11:6];  end
            I2:   begin next_state = I3;   addr_c = AW'(1) << 2; wdata_c = instr_q[17:12]; end
            I3:   begin next_state = I4;   addr_c = AW'(1) << 3; wdata_c = instr_q[23:18]; end
            I4:   begin next_state = EXEC; addr_c = AW'(1) << 4; wdata_c = instr_q[29:24]; end
            EXEC: begin
                next_state = RDPC;
                addr_c     = AW'(1) << 5;
                wdata_c    = {4'b0000, instr_q[31:30]};
            end
            RDPC: begin
                // The EXEC cycle is on the bus now, so hv_rdata carries the status
                if ((SKIP_OUT_READ != 0) && (hv_rdata[3:2] == 2'b00)) next_state = RESP;
                else                                                  next_state = RDOL;
                addr_c = AW'(1) << 6;
            end
            RDOL: begin next_state = RDOH; addr_c = AW'(1) << 7; end
            RDOH: begin next_state = RESP; addr_c = AW'(1) << 8; end
            RESP: begin
                if (rsp_valid && rsp_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // State, bus and response registers; bus_st names the cycle currently on the bus
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            bus_st     <= IDLE;
            cmd_ready  <= 1'b0;
            hv_addr    <= '0;
            hv_wdata   <= '0;
            rsp_valid  <= 1'b0;
            rsp_status <= '0;
            rsp_pc     <= '0;
            rsp_out    <= '0;
            exec_count <= '0;
            instr_q    <= '0;
            in1_q      <= '0;
            in2_q      <= '0;
            ld_in2_q   <= 1'b0;
        end else begin
            state     <= next_state;
            bus_st    <= state;
            cmd_ready <= (next_state == IDLE);
            hv_addr   <= addr_c;
            hv_wdata  <= wdata_c;
            rsp_valid <= (state == RESP) && !(rsp_valid && rsp_ready);

            if (accept) begin
                instr_q  <= cmd_instr;
                in1_q    <= cmd_in1;
                in2_q    <= cmd_in2;
                ld_in2_q <= cmd_ld_in2;
                rsp_out  <= '0;
            end

            if (state == EXEC) exec_count <= exec_count + COUNT_WIDTH'(1);

            case (bus_st)
                EXEC:    rsp_status    <= hv_rdata[3:0];
                RDPC:    rsp_pc        <= hv_rdata;
                RDOL:    rsp_out[7:0]  <= hv_rdata;
                RDOH:    rsp_out[11:8] <= hv_rdata[3:0];
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hovalaag_sequencer.sv
// Directed bench for hovalaag_sequencer against a small behavioural wrapper model.
module tb_hovalaag_sequencer;
    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [31:0]   cmd_instr;
    logic          cmd_ld_in1;
    logic          cmd_ld_in2;
    logic [11:0]   cmd_in1;
    logic [11:0]   cmd_in2;
    logic [9:0]    hv_addr;
    logic [5:0]    hv_wdata;
    logic [7:0]    hv_rdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [3:0]    rsp_status;
    logic [7:0]    rsp_pc;
    logic [11:0]   rsp_out;
    logic [CW-1:0] exec_count;

    int n_vec = 0;
    int n_err = 0;
    int bus_cnt = 0;
    logic [15:0] bus_q[$];
    logic [15:0] exp_q[$];

    // Wrapper model: captures the instruction, counts PC on execute, returns status/PC/W
    logic [31:0] cap;
    logic [7:0]  model_pc;
    logic [11:0] model_w;

    hovalaag_sequencer #(.SKIP_OUT_READ(1), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_instr(cmd_instr),
        .cmd_ld_in1(cmd_ld_in1), .cmd_ld_in2(cmd_ld_in2), .cmd_in1(cmd_in1), .cmd_in2(cmd_in2),
        .hv_addr(hv_addr), .hv_wdata(hv_wdata), .hv_rdata(hv_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
        .rsp_pc(rsp_pc), .rsp_out(rsp_out), .exec_count(exec_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) begin
            cap      <= '0;
            model_pc <= '0;
        end else begin
            case (hv_addr)
                10'h001: cap[5:0]   <= hv_wdata;
                10'h002: cap[11:6]  <= hv_wdata;
                10'h004: cap[17:12] <= hv_wdata;
                10'h008: cap[23:18] <= hv_wdata;
                10'h010: cap[29:24] <= hv_wdata;
                10'h020: begin cap[31:30] <= hv_wdata[1:0]; model_pc <= model_pc + 8'd1; end
                default: ;
            endcase
        end
    end

    always_comb begin
        hv_rdata = 8'h00;
        case (hv_addr)
            10'h020: hv_rdata = {4'b0000, cap[13], cap[14], cap[1], cap[0]};
            10'h040: hv_rdata = model_pc;
            10'h080: hv_rdata = model_w[7:0];
            10'h100: hv_rdata = {4'b0000, model_w[11:8]};
            default: hv_rdata = 8'h00;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus monitor: logs every non-idle cycle and checks the address stays one-hot
    always @(negedge clk) begin
        if (hv_addr != 10'h000) begin
            bus_q.push_back({hv_addr, hv_wdata});
            bus_cnt++;
        end
        if (reset === 1'b0) check("addr_onehot0", 32'($onehot0(hv_addr)), 32'd1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one command, scramble the cmd inputs after accept, wait for rsp_valid
    task automatic issue(input logic [31:0] instr, input logic l1, input logic l2,
                         input logic [11:0] i1, input logic [11:0] i2, output int lat);
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        bus_q.delete();
        cmd_valid  = 1'b1;
        cmd_instr  = instr;
        cmd_ld_in1 = l1;
        cmd_ld_in2 = l2;
        cmd_in1    = i1;
        cmd_in2    = i2;
        tick();
        cmd_valid  = 1'b0;
        cmd_instr  = ~instr;
        cmd_ld_in1 = ~l1;
        cmd_ld_in2 = ~l2;
        cmd_in1    = ~i1;
        cmd_in2    = ~i2;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic check_bus(input string tag);
        check({tag, "_len"}, 32'(bus_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < bus_q.size()) check($sformatf("%s_cyc%0d", tag, i), 32'(bus_q[i]), 32'(exp_q[i]));
        end
    endtask

    task automatic finish_rsp(input string tag);
        tick();
        check({tag, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        int lat;
        int nacc;
        int nrsp;
        int elapsed;
        logic [7:0] last_pc;
        logic seen;

        reset = 1'b1; cmd_valid = 1'b0; cmd_instr = '0; cmd_ld_in1 = 1'b0; cmd_ld_in2 = 1'b0;
        cmd_in1 = '0; cmd_in2 = '0; rsp_ready = 1'b1; model_w = 12'h000;
        repeat (3) tick();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_addr", 32'(hv_addr), 32'd0);
        check("rst_wdata", 32'(hv_wdata), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_fields", {8'h00, rsp_status, rsp_pc, rsp_out}, 32'd0);
        check("rst_exec_count", 32'(exec_count), 32'd0);
        reset = 1'b0;
        tick();
        check("post_rst_ready", 32'(cmd_ready), 32'd1);

        // Plain instruction, no loads, OUT read skipped
        issue(32'h0000_0000, 1'b0, 1'b0, 12'h000, 12'h000, lat);
        check("t1_latency", 32'(lat), 32'd9);
        exp_q = '{{10'h001, 6'h00}, {10'h002, 6'h00}, {10'h004, 6'h00}, {10'h008, 6'h00},
                  {10'h010, 6'h00}, {10'h020, 6'h00}, {10'h040, 6'h00}};
        check_bus("t1_bus");
        check("t1_status", 32'(rsp_status), 32'h0);
        check("t1_pc", 32'(rsp_pc), 32'h01);
        check("t1_out", 32'(rsp_out), 32'h000);
        check("t1_exec", 32'(exec_count), 32'd1);
        check("t1_addr_resp", 32'(hv_addr), 32'd0);
        finish_rsp("t1");

        // OUT1 valid: OUT read cycles happen
        model_w = 12'h5A7;
        issue(32'h0000_4000, 1'b0, 1'b0, 12'h000, 12'h000, lat);
        check("t3_latency", 32'(lat), 32'd11);
        exp_q = '{{10'h001, 6'h00}, {10'h002, 6'h00}, {10'h004, 6'h04}, {10'h008, 6'h00},
                  {10'h010, 6'h00}, {10'h020, 6'h00}, {10'h040, 6'h00}, {10'h080, 6'h00},
                  {10'h100, 6'h00}};
        check_bus("t3_bus");
        check("t3_status", 32'(rsp_status), 32'h4);
        check("t3_pc", 32'(rsp_pc), 32'h02);
        check("t3_out", 32'(rsp_out), 32'h5A7);
        check("t3_exec", 32'(exec_count), 32'd2);
        finish_rsp("t3");

        // Both IN loads; OUT skipped so rsp_out must read 0 after the previous 5A7
        issue(32'h8000_0041, 1'b1, 1'b1, 12'hABC, 12'h123, lat);
        check("t2_latency", 32'(lat), 32'd13);
        exp_q = '{{10'h040, 6'h3C}, {10'h080, 6'h2A}, {10'h100, 6'h23}, {10'h200, 6'h04},
                  {10'h001, 6'h01}, {10'h002, 6'h01}, {10'h004, 6'h00}, {10'h008, 6'h00},
                  {10'h010, 6'h00}, {10'h020, 6'h02}, {10'h040, 6'h00}};
        check_bus("t2_bus");
        check("t2_status", 32'(rsp_status), 32'h1);
        check("t2_pc", 32'(rsp_pc), 32'h03);
        check("t2_out", 32'(rsp_out), 32'h000);
        check("t2_exec", 32'(exec_count), 32'd3);
        finish_rsp("t2");

        // Host back-pressure: response held for 5 cycles, taken on the 6th
        model_w   = 12'h3C1;
        rsp_ready = 1'b0;
        issue(32'h0000_2000, 1'b0, 1'b0, 12'h000, 12'h000, lat);
        check("t4_latency", 32'(lat), 32'd11);
        check("t4_bus_len", 32'(bus_q.size()), 32'd9);
        for (int i = 0; i < 6; i++) begin
            if (i == 5) rsp_ready = 1'b1;
            check("t4_hold_valid", 32'(rsp_valid), 32'd1);
            check("t4_hold_fields", {8'h00, rsp_status, rsp_pc, rsp_out}, {8'h00, 4'h8, 8'h04, 12'h3C1});
            check("t4_hold_ready", 32'(cmd_ready), 32'd0);
            check("t4_hold_addr", 32'(hv_addr), 32'd0);
            tick();
        end
        check("t4_rsp_drop", 32'(rsp_valid), 32'd0);
        check("t4_ready_back", 32'(cmd_ready), 32'd1);
        check("t4_exec", 32'(exec_count), 32'd4);

        // Reset while the I2 bus cycle is out
        check("t5_cmd_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_instr = 32'h0000_0000; cmd_ld_in1 = 1'b0; cmd_ld_in2 = 1'b0;
        tick();
        cmd_valid = 1'b0;
        lat = 0;
        while (hv_addr !== 10'h004 && lat < 20) begin
            tick();
            lat++;
        end
        check("t5_reach_i2", 32'(hv_addr), 32'h004);
        reset = 1'b1;
        tick();
        check("t5_addr_cleared", 32'(hv_addr), 32'd0);
        check("t5_no_rsp", 32'(rsp_valid), 32'd0);
        check("t5_exec_cleared", 32'(exec_count), 32'd0);
        reset = 1'b0;
        tick();
        check("t5_ready_after", 32'(cmd_ready), 32'd1);
        seen = 1'b0;
        bus_q.delete();
        repeat (12) begin
            if (rsp_valid === 1'b1) seen = 1'b1;
            tick();
        end
        check("t5_dropped_cmd", {31'd0, seen}, 32'd0);
        check("t5_bus_quiet", 32'(bus_q.size()), 32'd0);
        issue(32'h0000_0000, 1'b0, 1'b0, 12'h000, 12'h000, lat);
        check("t5_latency", 32'(lat), 32'd9);
        check("t5_pc", 32'(rsp_pc), 32'h01);
        check("t5_exec", 32'(exec_count), 32'd1);
        finish_rsp("t5");

        // 2^CW+1 back-to-back commands: counter wraps to 1, ten cycles per step
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        cmd_valid = 1'b1; cmd_instr = 32'h0000_0000; cmd_ld_in1 = 1'b0; cmd_ld_in2 = 1'b0;
        bus_cnt = 0; nacc = 0; nrsp = 0; elapsed = 0; last_pc = 8'h00;
        while (nrsp < (1 << CW) + 1 && elapsed < 4000) begin
            if (cmd_valid && cmd_ready) nacc++;
            if (rsp_valid && rsp_ready) begin
                nrsp++;
                if (nrsp == (1 << CW) + 1) begin
                    cmd_valid = 1'b0;
                    last_pc   = rsp_pc;
                end
            end
            tick();
            elapsed++;
        end
        check("t6_responses", 32'(nrsp), 32'd257);
        check("t6_accepts", 32'(nacc), 32'd257);
        check("t6_cycles", 32'(elapsed), 32'd2570);
        check("t6_bus_cycles", 32'(bus_cnt), 32'd1799);
        check("t6_exec_wrap", 32'(exec_count), 32'd1);
        check("t6_last_pc", 32'(last_pc), 32'h01);
        check("t6_idle_ready", 32'(cmd_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1);
    end
endmodule
